stream_prefetch_ctrl: RTL and testbench
=======================================

# stream_prefetch_ctrl

Sequencer between the QSPI flash reader and the instruction decoder. Starts and restarts continuous flash read bursts, buffers incoming 20-bit instruction words in a small FIFO, and throttles the flash via hold when the FIFO nears full. It also detects the end-of-video marker to loop playback from the base address. It replaces the fixed three-stage shift buffer with a flow-controlled one.

## Interface
- WORD_W, 20: instruction word width
- DEPTH, 4: FIFO entries (power of two, ≥4)
- ADDR_W, 24: flash byte-address width
- BASE_ADDR, 24'h000000: first byte of the video stream
- END_WORD, 20'hFFFFF: end-of-video marker word
- GAP_CYCLES, 4: minimum cycles between spi_stop and the next spi_start (CS high time)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = play, 0 = stop and flush
- spi_start  out  1  one-cycle pulse: begin read burst at spi_addr
- spi_addr  out  ADDR_W  burst start address; always BASE_ADDR
- spi_stop  out  1  one-cycle pulse: end burst (raise CS)
- spi_pause  out  1  level; 1 = hold flash (drive HOLD_n low)
- spi_valid  in  1  word strobe from the reader
- spi_data  in  WORD_W  word from the reader
- dec_valid  out  1  FIFO head valid
- dec_data  out  WORD_W  FIFO head word
- dec_pop  in  1  decoder consumes the head word
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: write attempted while the FIFO was full
- underrun  out  1  sticky: dec_pop while dec_valid=0
- wrapped  out  1  one-cycle pulse when END_WORD is received

## Operation
- States: IDLE, START, STREAM, STOP, GAP.
- IDLE: outputs quiet. If enable=1, go to START next cycle.
- START: assert spi_start for exactly 1 cycle, then go to STREAM.
- STREAM:
  - spi_valid with spi_data≠END_WORD: push the word.
  - spi_valid with spi_data=END_WORD: do not push. Pulse wrapped, go to STOP.
- STOP: assert spi_stop for 1 cycle. Load the gap counter with GAP_CYCLES−1, go to GAP.
- GAP: decrement the counter. At 0, go to START if enable=1, else IDLE.
- enable=0 in any state other than IDLE:
  - pulse spi_stop that cycle unless the state is STOP or GAP
  - flush the FIFO (level←0)
  - go to IDLE
  - the sticky flags are not cleared
- spi_pause = (state==STREAM) && (level ≥ DEPTH−1). This leaves one slot for the word already in flight in the reader.
- FIFO behaviour:
  - Push and pop in the same cycle: both take effect, including when full.
  - Push when full with no pop: the word is dropped and overflow←1.
  - Pop when empty: ignored and underrun←1.
  - spi_valid outside STREAM is ignored: no push, no flag.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the write count minus the read count, range 0..DEPTH.

## Timing
- Reset values: state=IDLE; all pulses, spi_pause, dec_valid, overflow, underrun = 0; level=0; dec_data=0; spi_addr=BASE_ADDR.
- enable rising at cycle n: spi_start is high in cycle n+1.
- Push at edge k: dec_valid=1 and dec_data are valid after edge k (no fall-through).
- dec_pop at edge k: the next word, or dec_valid=0, appears after edge k.
- spi_pause is combinational from registered state and level. It asserts in the same cycle level reaches DEPTH−1.
- END_WORD at edge k:
  - wrapped and spi_stop are high during cycle k+1.
  - GAP occupies GAP_CYCLES cycles.
  - spi_start is high GAP_CYCLES+2 cycles after k.
- FIFO contents are unaffected by a wrap, so the decoder drains pre-marker words across the restart.
- The reset deassertion edge is not synchronised inside this block. The integrator supplies a synchronised rst.

## Structure
- Shared package holds: the state enum (IDLE/START/STREAM/STOP/GAP), WORD_W, and the END_WORD default.
- One sub-module: sync_fifo, holding the storage, pointers, level, and the overflow/underrun flags. The controller FSM instantiates it.
- The top-level wrapper replaces the three chained shift buffers with this block.

## Test plan
- Reset, then enable=1: spi_start pulses once in cycle 2 with spi_addr=0. level=0, dec_valid=0.
- Stream words 1,2,3 with no pops: level=3, spi_pause=1 once level=3. A 4th in-flight word is accepted, giving level=4. A 5th push sets overflow=1 and keeps level=4.
- From full, push and pop in the same cycle: level stays 4, dec_data advances to word 2, overflow unchanged.
- With words A,B in the FIFO, send 20'hFFFFF: it is not stored and wrapped pulses. spi_stop follows one cycle later; spi_start comes 6 cycles after the marker (GAP_CYCLES=4). A and B are still readable in order.
- Drop enable mid-STREAM with level=2: spi_stop pulses, level=0 next cycle, state is IDLE. Re-enabling gives spi_start after one cycle.
- dec_pop with an empty FIFO: underrun=1 and stays set through later traffic until rst.

Source files
------------

// File: rtl/stream_prefetch_ctrl_pkg.sv
// Shared types and defaults for the flash-to-decoder prefetch sequencer.
package stream_prefetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    STOP,
    GAP
  } state_e;

  localparam int unsigned DEF_WORD_W   = 20;
  localparam logic [19:0] DEF_END_WORD = 20'hFFFFF;

endpackage

// File: rtl/stream_prefetch_ctrl_sync_fifo.sv
// Registered-output FIFO holding decoded-instruction words, with sticky
// overflow/underrun flags and a synchronous flush.
module sync_fifo #(
  parameter int unsigned WORD_W = 20,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     pop,
  output logic [WORD_W-1:0]        rdata,
  output logic                     rvalid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udr_q, udr_d;
  logic              empty, full, do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udr_d    = udr_q;

    empty   = (cnt_q == '0);
    full    = (cnt_q == LW'(DEPTH));
    do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    do_push = push && (!full || do_pop);

    if (pop && empty)        udr_d = 1'b1;
    if (push && full && !pop) ovf_d = 1'b1;

    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udr_q    <= udr_d;
    end
  end

  assign rvalid   = (cnt_q != '0);
  assign rdata    = rvalid ? mem_q[rd_ptr_q] : '0;
  assign level    = cnt_q;
  assign overflow = ovf_q;
  assign underrun = udr_q;

endmodule

// File: rtl/stream_prefetch_ctrl.sv
// Burst sequencer between the QSPI flash reader and the instruction decoder:
// starts/loops read bursts, buffers words, and holds the flash near full.
module stream_prefetch_ctrl
  import stream_prefetch_ctrl_pkg::*;
#(
  parameter int unsigned       WORD_W     = DEF_WORD_W,
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [WORD_W-1:0] END_WORD   = WORD_W'(DEF_END_WORD),
  parameter int unsigned       GAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    spi_start,
  output logic [ADDR_W-1:0]       spi_addr,
  output logic                    spi_stop,
  output logic                    spi_pause,
  input  logic                    spi_valid,
  input  logic [WORD_W-1:0]       spi_data,
  output logic                    dec_valid,
  output logic [WORD_W-1:0]       dec_data,
  input  logic                    dec_pop,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    underrun,
  output logic                    wrapped
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wrapped_q, wrapped_d;
  logic          fifo_push, fifo_flush;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wrapped_d  = 1'b0;
    spi_start  = 1'b0;
    spi_stop   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    // Dropping enable aborts from any active state; a burst still open gets closed.
    if (state_q != IDLE && !enable) begin
      fifo_flush = 1'b1;
      state_d    = IDLE;
      if (state_q inside {START, STREAM, STOP}) spi_stop = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (enable) state_d = START;
        START: begin
          spi_start = 1'b1;
          state_d   = STREAM;
        end
        STREAM: begin
          if (spi_valid) begin
            if (spi_data == END_WORD) begin
              wrapped_d = 1'b1;
              state_d   = STOP;
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
        STOP: begin
          spi_stop = 1'b1;
          gap_d    = GW'(GAP_CYCLES - 1);
          state_d  = GAP;
        end
        GAP: begin
          if (gap_q == '0) state_d = START;
          else             gap_d   = gap_q - GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      wrapped_q <= wrapped_d;
    end
  end

  sync_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .wdata    (spi_data),
    .pop      (dec_pop),
    .rdata    (dec_data),
    .rvalid   (dec_valid),
    .level    (level),
    .overflow (overflow),
    .underrun (underrun)
  );

  assign spi_addr  = BASE_ADDR;
  assign spi_pause = (state_q == STREAM) && (level >= LW'(DEPTH - 1));
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-scheduled queue model of the sequencer.
module tb_stream_prefetch_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int          GAP   = 4;
  localparam logic [19:0] ENDW  = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        rst, enable, spi_valid, dec_pop;
  logic [19:0] spi_data;
  logic        spi_start, spi_stop, spi_pause, dec_valid, overflow, underrun, wrapped;
  logic [23:0] spi_addr;
  logic [19:0] dec_data;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  stream_prefetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .spi_start (spi_start),
    .spi_addr  (spi_addr),
    .spi_stop  (spi_stop),
    .spi_pause (spi_pause),
    .spi_valid (spi_valid),
    .spi_data  (spi_data),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .dec_pop   (dec_pop),
    .level     (level),
    .overflow  (overflow),
    .underrun  (underrun),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  // Model: a word queue plus a schedule of when the next burst start is due.
  logic [19:0] q[$];
  bit m_on, m_strm, m_stop_due, m_wrap, m_ov, m_ur;
  int m_until;

  function automatic void model_reset();
    q.delete();
    m_on = 0; m_strm = 0; m_stop_due = 0; m_wrap = 0; m_ov = 0; m_ur = 0;
    m_until = -1;
  endfunction

  function automatic void model_edge();
    bit push_ok, wrap_now, popped;
    int sz;
    sz       = q.size();
    popped   = 0;
    push_ok  = m_on && enable && m_strm && spi_valid && spi_data != ENDW;
    wrap_now = m_on && enable && m_strm && spi_valid && spi_data == ENDW;
    if (dec_pop) begin
      if (sz == 0) m_ur = 1;
      else begin void'(q.pop_front()); popped = 1; end
    end
    if (push_ok) begin
      if (sz < DEPTH || popped) q.push_back(spi_data);
      else m_ov = 1;
    end
    m_wrap = wrap_now;
    if (!m_on) begin
      if (enable) begin m_on = 1; m_until = 0; end
    end else if (!enable) begin
      m_on = 0; m_strm = 0; m_stop_due = 0; m_until = -1; q.delete();
    end else if (m_stop_due) begin
      m_stop_due = 0; m_until = GAP;
    end else if (m_until == 0) begin
      m_until = -1; m_strm = 1;
    end else if (m_until > 0) begin
      m_until--;
    end else if (wrap_now) begin
      m_strm = 0; m_stop_due = 1;
    end
  endfunction

  function automatic bit exp_start();
    return m_on && enable && m_until == 0;
  endfunction
  function automatic bit exp_stop();
    return m_on && (m_stop_due || (!enable && m_until <= 0));
  endfunction
  function automatic bit exp_pause();
    return m_strm && q.size() >= DEPTH - 1;
  endfunction
  function automatic logic [19:0] exp_head();
    return (q.size() != 0) ? q[0] : 20'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [19:0] rnd_word();
    return 20'($urandom_range(0, 20'hFFFFE));
  endfunction

  task automatic wait_stream();
    int n = 0;
    while (!m_strm && n < 16) begin tick(); n++; end
    total++;
    if (!m_strm) begin bad++; $display("FAIL wait_stream got=timeout exp=stream"); end
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; spi_valid = 0; spi_data = '0; dec_pop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    total++; if ({spi_start, spi_stop, spi_pause, dec_valid, overflow, underrun, wrapped} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000000",
        {spi_start, spi_stop, spi_pause, dec_valid, overflow, underrun, wrapped}); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (dec_data !== 20'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dec_data); end
    total++; if (spi_addr !== 24'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", spi_addr); end
  endtask

  task automatic test_start();
    enable = 1;
    #1;
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL start_early got=%b exp=0", spi_start); end
    tick();
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b exp=1", spi_start); end
    total++; if (spi_addr !== 24'h0) begin bad++; $display("FAIL start_addr got=%h exp=0", spi_addr); end
    total++; if (level !== 3'd0 || dec_valid !== 1'b0) begin
      bad++; $display("FAIL start_empty got=%0d/%b exp=0/0", level, dec_valid); end
    tick();
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL start_once got=%b exp=0", spi_start); end
    wait_stream();
  endtask

  logic [19:0] w[6];

  task automatic test_fill_overflow();
    for (int i = 0; i < 6; i++) w[i] = rnd_word();
    for (int i = 0; i < 3; i++) begin
      spi_valid = 1; spi_data = w[i];
      #1;
      total++; if (level !== 3'(i) || spi_pause !== 1'(i >= 3)) begin
        bad++; $display("FAIL fill_%0d got=%0d/%b exp=%0d/0", i, level, spi_pause, i); end
      tick();
    end
    spi_valid = 0;
    #1;
    total++; if (level !== 3'd3 || spi_pause !== 1'b1) begin
      bad++; $display("FAIL fill_pause got=%0d/%b exp=3/1", level, spi_pause); end
    spi_valid = 1; spi_data = w[3];
    tick();
    total++; if (level !== 3'd4 || overflow !== 1'b0) begin
      bad++; $display("FAIL fill_inflight got=%0d/%b exp=4/0", level, overflow); end
    spi_data = w[4];
    tick();
    spi_valid = 0;
    #1;
    total++; if (level !== 3'd4 || overflow !== 1'b1) begin
      bad++; $display("FAIL fill_overflow got=%0d/%b exp=4/1", level, overflow); end
    total++; if (dec_data !== w[0]) begin bad++; $display("FAIL fill_head got=%h exp=%h", dec_data, w[0]); end
  endtask

  task automatic test_push_pop_full();
    spi_valid = 1; spi_data = w[5]; dec_pop = 1;
    tick();
    spi_valid = 0; dec_pop = 0;
    #1;
    total++; if (level !== 3'd4) begin bad++; $display("FAIL pp_level got=%0d exp=4", level); end
    total++; if (dec_data !== w[1]) begin bad++; $display("FAIL pp_head got=%h exp=%h", dec_data, w[1]); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pp_overflow got=%b exp=1", overflow); end
  endtask

  task automatic test_wrap();
    logic [19:0] a, b;
    dec_pop = 1;
    tick(); tick();
    dec_pop = 0;
    a = q[0]; b = q[1];
    total++; if (a !== w[3] || b !== w[5]) begin bad++; $display("FAIL wrap_model got=%h,%h exp=%h,%h", a, b, w[3], w[5]); end
    spi_valid = 1; spi_data = ENDW;
    tick();
    spi_valid = 0;
    #1;
    total++; if (wrapped !== 1'b1 || spi_stop !== 1'b1) begin
      bad++; $display("FAIL wrap_pulse got=%b/%b exp=1/1", wrapped, spi_stop); end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level got=%0d exp=2", level); end
    for (int c = 2; c <= 8; c++) begin
      tick();
      total++; if (spi_start !== 1'(c == GAP + 2) || wrapped !== 1'b0) begin
        bad++; $display("FAIL wrap_restart_c%0d got=%b/%b exp=%b/0", c, spi_start, wrapped, c == GAP + 2); end
    end
    total++; if (dec_data !== a) begin bad++; $display("FAIL wrap_a got=%h exp=%h", dec_data, a); end
    dec_pop = 1;
    tick();
    total++; if (dec_data !== b) begin bad++; $display("FAIL wrap_b got=%h exp=%h", dec_data, b); end
    tick();
    dec_pop = 0;
    #1;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b exp=0", dec_valid); end
  endtask

  task automatic test_disable();
    spi_valid = 1; spi_data = rnd_word();
    tick();
    spi_data = rnd_word();
    tick();
    spi_valid = 0;
    #1;
    total++; if (level !== 3'd2) begin bad++; $display("FAIL dis_pre got=%0d exp=2", level); end
    enable = 0;
    #1;
    total++; if (spi_stop !== 1'b1) begin bad++; $display("FAIL dis_stop got=%b exp=1", spi_stop); end
    tick();
    total++; if (level !== 3'd0 || dec_valid !== 1'b0 || spi_stop !== 1'b0) begin
      bad++; $display("FAIL dis_flush got=%0d/%b/%b exp=0/0/0", level, dec_valid, spi_stop); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL dis_sticky got=%b exp=1", overflow); end
    tick();
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL dis_idle got=%b exp=0", spi_start); end
    enable = 1;
    #1;
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL reen_early got=%b exp=0", spi_start); end
    tick();
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL reen_start got=%b exp=1", spi_start); end
    wait_stream();
  endtask

  task automatic test_underrun();
    dec_pop = 1;
    tick();
    dec_pop = 0;
    total++; if (underrun !== 1'b1 || dec_valid !== 1'b0) begin
      bad++; $display("FAIL udr_set got=%b/%b exp=1/0", underrun, dec_valid); end
    spi_valid = 1; spi_data = rnd_word();
    tick();
    spi_valid = 0; dec_pop = 1;
    tick();
    dec_pop = 0;
    tick();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL udr_sticky got=%b exp=1", underrun); end
  endtask

  task automatic test_random();
    rst = 1; model_reset();
    enable = 0; spi_valid = 0; dec_pop = 0;
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 24) != 0);
      spi_valid = $urandom_range(0, 1) == 1;
      spi_data  = ($urandom_range(0, 11) == 0) ? ENDW : rnd_word();
      dec_pop   = ($urandom_range(0, 9) < 4);
      #1;
      total++; if (spi_start !== exp_start()) begin bad++; $display("FAIL rnd_start c=%0d got=%b exp=%b", c, spi_start, exp_start()); end
      total++; if (spi_stop !== exp_stop()) begin bad++; $display("FAIL rnd_stop c=%0d got=%b exp=%b", c, spi_stop, exp_stop()); end
      total++; if (spi_pause !== exp_pause()) begin bad++; $display("FAIL rnd_pause c=%0d got=%b exp=%b", c, spi_pause, exp_pause()); end
      total++; if (wrapped !== m_wrap) begin bad++; $display("FAIL rnd_wrap c=%0d got=%b exp=%b", c, wrapped, m_wrap); end
      total++; if (level !== 3'(q.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); end
      total++; if (dec_valid !== (q.size() != 0) || dec_data !== exp_head()) begin
        bad++; $display("FAIL rnd_head c=%0d got=%b/%h exp=%b/%h", c, dec_valid, dec_data, q.size() != 0, exp_head()); end
      total++; if (overflow !== m_ov || underrun !== m_ur) begin
        bad++; $display("FAIL rnd_flags c=%0d got=%b/%b exp=%b/%b", c, overflow, underrun, m_ov, m_ur); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_fill_overflow();
    test_push_pop_full();
    test_wrap();
    test_disable();
    test_underrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
